// File: rtl/maxpool3d_2x2x2_if.sv
// Streaming voxel bus between conv3d and the 2x2x2 max-pool stage.
// The master drives the input voxel stream. The slave returns the pooled stream and status flags.
interface maxpool3d_2x2x2_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] voxel_in;
    logic              valid_in;
    logic              last_in;
    logic [DATA_W-1:0] voxel_out;
    logic              valid_out;
    logic              last_out;
    logic              done;
    logic              err;

    modport master (
        output voxel_in, valid_in, last_in,
        input  voxel_out, valid_out, last_out, done, err
    );

    modport slave (
        input  voxel_in, valid_in, last_in,
        output voxel_out, valid_out, last_out, done, err
    );
endinterface

// File: rtl/maxpool3d_2x2x2.sv
// Streaming 2x2x2 stride-2 max-pool over a raster-ordered DxHxW volume.
// Pair max is taken along x, row max against a W/2 row buffer, and plane max against an (H/2)*(W/2) plane buffer.
module maxpool3d_2x2x2 #(
    parameter int D      = 8,
    parameter int H      = 64,
    parameter int W      = 64,
    parameter int DATA_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    maxpool3d_2x2x2_if.slave   bus
);
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int ZW = $clog2(D);
    localparam int RN = W / 2;
    localparam int PN = (H / 2) * (W / 2);
    localparam int RW = (RN > 1) ? $clog2(RN) : 1;
    localparam int PW = (PN > 1) ? $clog2(PN) : 1;

    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ZW-1:0]     z_q, z_d;
    logic [DATA_W-1:0] pmax_q, pmax_d;
    logic [DATA_W-1:0] vout_q, vout_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] rowbuf   [RN];
    logic [DATA_W-1:0] planebuf [PN];

    logic [RW-1:0]     ridx;
    logic [PW-1:0]     pidx;
    logic [DATA_W-1:0] row_rd, pl_rd, m, m2, res;
    logic              x_end, y_end, z_end, final_pos, bad_last;
    logic              row_we, plane_we;

    always_comb begin
        x_end     = (x_q == XW'(W - 1));
        y_end     = (y_q == YW'(H - 1));
        z_end     = (z_q == ZW'(D - 1));
        final_pos = x_end && y_end && z_end;
        bad_last  = bus.last_in && !final_pos;

        ridx   = RW'(x_q >> 1);
        pidx   = PW'(32'(y_q >> 1) * 32'(W / 2) + 32'(x_q >> 1));
        row_rd = rowbuf[ridx];
        pl_rd  = planebuf[pidx];
        m      = (bus.voxel_in > pmax_q) ? bus.voxel_in : pmax_q;
        m2     = (row_rd > m) ? row_rd : m;
        res    = (pl_rd > m2) ? pl_rd : m2;

        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        pmax_d   = pmax_q;
        vout_d   = vout_q;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        done_d   = last_q ? 1'b1 : done_q;
        err_d    = err_q;
        row_we   = 1'b0;
        plane_we = 1'b0;

        if (bus.valid_in) begin
            done_d = 1'b0;
            if (bad_last) begin
                // Premature last: drop this voxel and restart the volume at the origin.
                x_d   = '0;
                y_d   = '0;
                z_d   = '0;
                err_d = 1'b1;
            end else begin
                if (x_end) begin
                    x_d = '0;
                    if (y_end) begin
                        y_d = '0;
                        z_d = z_end ? '0 : z_q + ZW'(1);
                    end else begin
                        y_d = y_q + YW'(1);
                    end
                end else begin
                    x_d = x_q + XW'(1);
                end

                if (!x_q[0]) begin
                    pmax_d = bus.voxel_in;
                end else if (!y_q[0]) begin
                    row_we = 1'b1;
                end else if (!z_q[0]) begin
                    plane_we = 1'b1;
                end else begin
                    vout_d  = res;
                    valid_d = 1'b1;
                    last_d  = final_pos;
                end

                if (final_pos && !bus.last_in) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            pmax_q  <= '0;
            vout_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            pmax_q  <= pmax_d;
            vout_q  <= vout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (row_we) begin
            rowbuf[ridx] <= m;
        end
        if (plane_we) begin
            planebuf[pidx] <= m2;
        end
    end

    assign bus.voxel_out = vout_q;
    assign bus.valid_out = valid_q;
    assign bus.last_out  = last_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_maxpool3d_2x2x2.sv
// Directed bench for maxpool3d_2x2x2.
// A 2x4x4 instance covers the framing and timing cases, and a default 8x64x64 instance is checked against a reference pool.
module tb_maxpool3d_2x2x2;
    localparam int DW = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maxpool3d_2x2x2_if #(.DATA_W(DW)) s_if ();
    maxpool3d_2x2x2_if #(.DATA_W(DW)) b_if ();

    maxpool3d_2x2x2 #(.D(2), .H(4), .W(4), .DATA_W(DW)) u_small (
        .clk (clk),
        .rst (rst),
        .bus (s_if)
    );

    maxpool3d_2x2x2 #(.DATA_W(DW)) u_big (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] v;
        bit            last;
        int            c;
    } obs_t;

    typedef struct {
        string         name;
        int            pat;
        bit            gaps;
        logic [DW-1:0] exp [4];
    } vec_t;

    obs_t          sq [$];
    obs_t          bq [$];
    logic [DW-1:0] ev [$];
    int            et [$];
    int            sent_cyc [64];
    int            trig [4] = '{21, 23, 29, 31};
    logic [DW-1:0] bigv [32768];
    logic [DW-1:0] bev [$];
    vec_t          tbl [3];
    obs_t          mo;

    always @(negedge clk) begin
        if (s_if.valid_out) begin
            mo.v = s_if.voxel_out; mo.last = s_if.last_out; mo.c = cyc;
            sq.push_back(mo);
        end
        if (b_if.valid_out) begin
            mo.v = b_if.voxel_out; mo.last = b_if.last_out; mo.c = cyc;
            bq.push_back(mo);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic s_send(input logic [DW-1:0] v, input bit l, input int tag);
        @(negedge clk);
        s_if.voxel_in = v;
        s_if.valid_in = 1'b1;
        s_if.last_in  = l;
        sent_cyc[tag] = cyc;
    endtask

    task automatic s_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_if.valid_in = 1'b0;
            s_if.last_in  = 1'b0;
        end
    endtask

    task automatic b_send(input logic [DW-1:0] v, input bit l);
        @(negedge clk);
        b_if.voxel_in = v;
        b_if.valid_in = 1'b1;
        b_if.last_in  = l;
    endtask

    task automatic b_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            b_if.valid_in = 1'b0;
            b_if.last_in  = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] stim(input int pat, input int i);
        if (pat == 0) return DW'(i);
        return (i == 5) ? '1 : '0;
    endfunction

    task automatic clear_exp();
        sq.delete();
        ev.delete();
        et.delete();
    endtask

    task automatic push_ramp_exp(input int off, input int tagbase);
        for (int k = 0; k < 4; k++) begin
            ev.push_back(DW'(trig[k] + off));
            et.push_back(tagbase + trig[k]);
        end
    endtask

    task automatic check_q(input string nm);
        check($sformatf("%s count", nm), sq.size(), ev.size());
        for (int k = 0; k < sq.size() && k < ev.size(); k++) begin
            check($sformatf("%s value[%0d]", nm, k), sq[k].v, ev[k]);
            check($sformatf("%s last[%0d]", nm, k), sq[k].last, (et[k] % 32 == 31));
            check($sformatf("%s latency[%0d]", nm, k), sq[k].c, sent_cyc[et[k]] + 1);
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, " valid_out"}, s_if.valid_out, 0);
        check({nm, " voxel_out"}, s_if.voxel_out, 0);
        check({nm, " last_out"}, s_if.last_out, 0);
        check({nm, " done"}, s_if.done, 0);
        check({nm, " err"}, s_if.err, 0);
    endtask

    initial begin
        tbl[0].name = "ramp";   tbl[0].pat = 0; tbl[0].gaps = 1'b0; tbl[0].exp = '{21, 23, 29, 31};
        tbl[1].name = "gapped"; tbl[1].pat = 0; tbl[1].gaps = 1'b1; tbl[1].exp = '{21, 23, 29, 31};
        tbl[2].name = "spike";  tbl[2].pat = 1; tbl[2].gaps = 1'b0; tbl[2].exp = '{4095, 0, 0, 0};

        s_if.voxel_in = '0; s_if.valid_in = 1'b0; s_if.last_in = 1'b0;
        b_if.voxel_in = '0; b_if.valid_in = 1'b0; b_if.last_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        for (int t = 0; t < 3; t++) begin
            clear_exp();
            for (int i = 0; i < 32; i++) begin
                s_send(stim(tbl[t].pat, i), (i == 31), i);
                if (tbl[t].gaps) s_idle(1);
            end
            if (!tbl[t].gaps) s_idle(1);
            s_idle(1);
            check({tbl[t].name, " done"}, s_if.done, 1);
            check({tbl[t].name, " err"}, s_if.err, 0);
            for (int k = 0; k < 4; k++) begin
                ev.push_back(tbl[t].exp[k]);
                et.push_back(trig[k]);
            end
            check_q(tbl[t].name);
        end

        // Two volumes back to back; done was left high by the previous volume.
        clear_exp();
        for (int vol = 0; vol < 2; vol++) begin
            for (int i = 0; i < 32; i++) begin
                s_send(DW'(vol * 100 + i), (i == 31), vol * 32 + i);
                if (i == 1) check($sformatf("b2b done vol%0d", vol), s_if.done, 0);
            end
        end
        push_ramp_exp(0, 0);
        push_ramp_exp(100, 32);
        s_idle(2);
        check("b2b done end", s_if.done, 1);
        check_q("b2b");

        // Premature last_in on voxel 10, then a clean volume.
        check("framing err before", s_if.err, 0);
        clear_exp();
        for (int i = 0; i <= 10; i++) s_send(DW'(i), (i == 10), i);
        s_idle(1);
        check("framing err set", s_if.err, 1);
        check("framing no output", sq.size(), 0);
        for (int i = 0; i < 32; i++) s_send(DW'(i), (i == 31), i);
        s_idle(2);
        push_ramp_exp(0, 0);
        check_q("resync");
        check("framing err sticky", s_if.err, 1);

        // Reset in the middle of a volume.
        clear_exp();
        for (int i = 0; i <= 20; i++) s_send(DW'(i), 1'b0, i);
        @(negedge clk);
        s_if.valid_in = 1'b0;
        rst = 1'b1;
        #1;
        check_idle_outputs("midreset");
        repeat (2) @(negedge clk);
        check("midreset hold valid_out", s_if.valid_out, 0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) s_send(DW'(i), (i == 31), i);
        s_idle(2);
        push_ramp_exp(0, 0);
        check_q("after reset");
        check("after reset err", s_if.err, 0);
        check("after reset done", s_if.done, 1);

        // Default geometry against a reference pool of random data.
        for (int i = 0; i < 32768; i++) bigv[i] = DW'($urandom);
        for (int oz = 0; oz < 4; oz++)
            for (int oy = 0; oy < 32; oy++)
                for (int ox = 0; ox < 32; ox++) begin
                    logic [DW-1:0] mx;
                    mx = '0;
                    for (int dz = 0; dz < 2; dz++)
                        for (int dy = 0; dy < 2; dy++)
                            for (int dx = 0; dx < 2; dx++) begin
                                int idx;
                                idx = (2 * oz + dz) * 4096 + (2 * oy + dy) * 64 + 2 * ox + dx;
                                if (bigv[idx] > mx) mx = bigv[idx];
                            end
                    bev.push_back(mx);
                end
        bq.delete();
        for (int i = 0; i < 32768; i++) begin
            b_send(bigv[i], (i == 32767));
            if ($urandom_range(0, 7) == 0) b_idle(1);
        end
        b_idle(3);
        check("big count", bq.size(), 4096);
        begin
            int nl;
            nl = 0;
            for (int k = 0; k < bq.size() && k < 4096; k++) begin
                check($sformatf("big value[%0d]", k), bq[k].v, bev[k]);
                if (bq[k].last) nl++;
            end
            check("big last count", nl, 1);
            if (bq.size() > 0) check("big final last", bq[bq.size() - 1].last, 1);
        end
        check("big err", b_if.err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
